// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: drains the uart receive holding register into a DEPTH-entry
// byte FIFO and presents the buffered bytes on a valid/ready stream.
// Each byte takes IDLE -> UNLOAD -> CAPTURE. The uart loads rx_data on the
// unload pulse, so rx_empty is only trusted again once CAPTURE has passed.
module uart_rx_fifo #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int AFULL_LVL = 12
) (
   input  logic          rxclk,
   input  logic          reset_n,
   input  logic          rx_empty,
   input  logic [7:0]    rx_data,
   output logic          uld_rx_data,
   input  logic          flush,
   output logic          out_valid,
   output logic [7:0]    out_data,
   input  logic          out_ready,
   output logic [AW:0]   count,
   output logic          full,
   output logic          almost_full,
   output logic          overflow_seen
);

   localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_AFULL = (AW+1)'(AFULL_LVL);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   typedef enum logic [1:0] {IDLE, UNLOAD, CAPTURE} state_t;

   state_t        state;
   state_t        state_d;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          discard;
   logic          wr_en;
   logic          pop;
   logic          ovf_set;

   assign out_valid   = (count != '0);
   assign out_data    = mem[rd_ptr];
   assign full        = (count == CNT_DEPTH);
   assign almost_full = (count >= CNT_AFULL);

   // A flush in the same cycle wins over the pop.
   assign pop = out_valid && out_ready && !flush;

   // Next-state decode: start an unload only when there is room and no flush;
   // a waiting byte seen while full marks an overflow instead.
   always_comb begin
      state_d = state;
      wr_en   = 1'b0;
      ovf_set = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_empty && full) begin
               ovf_set = 1'b1;
            end
            if (!rx_empty && !full && !flush) begin
               state_d = UNLOAD;
            end
         end
         UNLOAD: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            wr_en   = !flush && !discard;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register plus the registered unload pulse; a flush seen during
   // UNLOAD is remembered so the following CAPTURE drops its byte.
   always_ff @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         uld_rx_data <= 1'b0;
         discard     <= 1'b0;
      end else begin
         state       <= state_d;
         uld_rx_data <= (state_d == UNLOAD);
         discard     <= (state == UNLOAD) && flush;
      end
   end

   // Pointers, occupancy and the sticky overflow flag; flush clears them all.
   always_ff @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         overflow_seen <= 1'b0;
      end else if (flush) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         overflow_seen <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({wr_en, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (ovf_set) begin
            overflow_seen <= 1'b1;
         end
      end
   end

   // Byte storage; data is not reset, so only occupancy decides what is valid.
   always_ff @(posedge rxclk) begin
      if (wr_en) begin
         mem[wr_ptr] <= rx_data;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized bench for uart_rx_fifo with a
// behavioural uart responder and a queue-based FIFO reference model.
module tb_uart_rx_fifo;

   localparam int DEPTH     = 16;
   localparam int AW        = 4;
   localparam int AFULL_LVL = 12;

   logic          rxclk = 1'b0;
   logic          reset_n;
   logic          rx_empty;
   logic [7:0]    rx_data;
   logic          uld_rx_data;
   logic          flush;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_ready;
   logic [AW:0]   count;
   logic          full;
   logic          almost_full;
   logic          overflow_seen;

   always #5 rxclk = ~rxclk;

   uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .AFULL_LVL(AFULL_LVL)) dut (
      .rxclk         (rxclk),
      .reset_n       (reset_n),
      .rx_empty      (rx_empty),
      .rx_data       (rx_data),
      .uld_rx_data   (uld_rx_data),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_ready     (out_ready),
      .count         (count),
      .full          (full),
      .almost_full   (almost_full),
      .overflow_seen (overflow_seen)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state
   byte unsigned exp_q[$];     // bytes the FIFO should hold, head first
   byte unsigned src_q[$];     // bytes the uart still has to receive
   bit           hold;         // uart holding register has a byte
   byte unsigned hold_byte;
   bit           cap_next;     // uart was unloaded; data shows next cycle
   byte unsigned cap_byte;
   bit           discard;
   bit           uld_m1, uld_m2;
   bit           p_rx_empty, p_flush;
   int           p_size;
   bit           exp_ovf;
   int           pulses = 0;

   // Stimulus knobs
   bit           rdy;
   bit           fl;
   int           rdy_mode;     // 0: rdy, 1: only on capture cycles, 2: random
   int           fl_mode;      // 0: fl, 1: on capture cycle, 2: on unload cycle

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      src_q.delete();
      hold       = 1'b0;
      cap_next   = 1'b0;
      discard    = 1'b0;
      uld_m1     = 1'b0;
      uld_m2     = 1'b0;
      p_rx_empty = 1'b1;
      p_flush    = 1'b0;
      p_size     = 0;
      exp_ovf    = 1'b0;
   endtask

   // One clock cycle: check outputs at the falling edge, play the uart,
   // drive ready/flush, then advance the reference model to the next edge.
   task automatic cyc();
      bit exp_uld, cap_now, idle_now, r, f, wr, pop;
      int sz;
      @(negedge rxclk);
      sz      = exp_q.size();
      exp_uld = !p_rx_empty && (p_size < DEPTH) && !p_flush && !uld_m1 && !uld_m2;
      chk("uld", uld_rx_data, exp_uld);
      chk("count", count, sz);
      chk("valid", out_valid, sz != 0);
      chk("full", full, sz == DEPTH);
      chk("afull", almost_full, sz >= AFULL_LVL);
      chk("ovf", overflow_seen, exp_ovf);
      if (sz != 0) chk("data", out_data, exp_q[0]);

      cap_now  = cap_next;
      idle_now = !uld_rx_data && !cap_now;
      f = fl;
      if (fl_mode == 1 && cap_now) f = 1'b1;
      if (fl_mode == 2 && uld_rx_data) f = 1'b1;
      r = rdy;
      if (rdy_mode == 1) r = cap_now;
      if (rdy_mode == 2) r = ($urandom_range(0, 2) == 0);

      wr = 1'b0;
      if (cap_now) begin
         rx_data  = cap_byte;
         rx_empty = 1'b1;
         wr       = !discard && !f;
         cap_next = 1'b0;
      end else if (uld_rx_data) begin
         cap_next = 1'b1;
         cap_byte = hold_byte;
         hold     = 1'b0;
         rx_data  = ~hold_byte;
         discard  = f;
         pulses++;
      end else if (!hold && src_q.size() != 0) begin
         hold      = 1'b1;
         hold_byte = src_q.pop_front();
         rx_empty  = 1'b0;
         rx_data   = 8'($urandom);
      end
      flush     = f;
      out_ready = r;

      pop = (sz != 0) && r && !f;
      if (f) exp_ovf = 1'b0;
      else if (idle_now && !rx_empty && sz == DEPTH) exp_ovf = 1'b1;
      p_size     = sz;
      p_rx_empty = rx_empty;
      p_flush    = f;
      uld_m2     = uld_m1;
      uld_m1     = uld_rx_data;
      if (f) begin
         exp_q.delete();
      end else begin
         if (pop) void'(exp_q.pop_front());
         if (wr) exp_q.push_back(cap_byte);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      reset_n = 1'b0; rx_empty = 1'b1; rx_data = 8'h00; flush = 1'b0; out_ready = 1'b0;
      rdy = 1'b0; fl = 1'b0; rdy_mode = 0; fl_mode = 0;
      model_reset();
      repeat (3) @(posedge rxclk);
      #1;
      chk("rst_uld", uld_rx_data, 0);
      chk("rst_count", count, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_full", full, 0);
      chk("rst_afull", almost_full, 0);
      chk("rst_ovf", overflow_seen, 0);
      @(negedge rxclk);
      reset_n = 1'b1;

      // Idle after reset: no byte waiting, no pulse
      repeat (20) cyc();
      chk("idle_pulses", pulses, 0);

      // Single byte then pop
      src_q.push_back(8'hA5);
      repeat (6) cyc();
      chk("single_pulses", pulses, 1);
      chk("single_count", count, 1);
      chk("single_data", out_data, 8'hA5);
      rdy = 1'b1; cyc();
      rdy = 1'b0; cyc();
      chk("single_popped", count, 0);

      // Fill to full, 17th byte waits in the uart
      for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
      repeat (16 * 3 + 4) cyc();
      chk("fill_full", full, 1);
      chk("fill_count", count, 16);
      src_q.push_back(8'h77);
      repeat (8) cyc();
      chk("stall_pulses", pulses, 17);
      chk("stall_ovf", overflow_seen, 1);
      rdy = 1'b1; cyc();
      rdy = 1'b0;
      repeat (5) cyc();
      chk("resume_pulses", pulses, 18);
      chk("resume_count", count, 16);
      rdy = 1'b1;
      repeat (18) cyc();
      rdy = 1'b0;
      chk("drain_count", count, 0);

      // Flush clears the sticky overflow
      fl = 1'b1; cyc();
      fl = 1'b0; cyc();
      chk("flush_ovf", overflow_seen, 0);

      // Write and pop together at count 5, across pointer wrap
      for (int i = 0; i < 5; i++) src_q.push_back(8'($urandom));
      repeat (20) cyc();
      chk("wp_start", count, 5);
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) src_q.push_back(8'($urandom));
      repeat (40 * 3 + 2) cyc();
      chk("wp_hold5", count, 5);

      // Random traffic with random ready
      rdy_mode = 2;
      for (int i = 0; i < 60; i++) src_q.push_back(8'($urandom));
      repeat (300) cyc();
      rdy_mode = 0; rdy = 1'b1;
      repeat (24) cyc();
      rdy = 1'b0;
      chk("rand_drained", count, 0);

      // Flush during CAPTURE of 8'h3C with three bytes stored
      src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
      repeat (12) cyc();
      chk("fc_pre", count, 3);
      base = pulses;
      fl_mode = 1;
      src_q.push_back(8'h3C);
      repeat (6) cyc();
      fl_mode = 0;
      chk("fc_pulse", pulses, base + 1);
      chk("fc_count", count, 0);
      chk("fc_ovf", overflow_seen, 0);
      src_q.push_back(8'h5A);
      repeat (6) cyc();
      chk("fc_next_count", count, 1);
      chk("fc_next_data", out_data, 8'h5A);

      // Flush during UNLOAD also discards the byte
      fl_mode = 2;
      src_q.push_back(8'hC3);
      repeat (6) cyc();
      fl_mode = 0;
      repeat (2) cyc();
      chk("fu_count", count, 0);

      // Async reset while the unload pulse is high
      src_q.push_back(8'h10); src_q.push_back(8'h20);
      repeat (8) cyc();
      chk("ar_pre", count, 2);
      src_q.push_back(8'h30);
      for (int i = 0; i < 10 && !uld_rx_data; i++) cyc();
      chk("ar_in_unload", uld_rx_data, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("ar_uld", uld_rx_data, 0);
      chk("ar_count", count, 0);
      chk("ar_valid", out_valid, 0);
      chk("ar_full", full, 0);
      chk("ar_afull", almost_full, 0);
      chk("ar_ovf", overflow_seen, 0);
      model_reset();
      rx_empty = 1'b1; flush = 1'b0; out_ready = 1'b0;
      base = pulses;
      repeat (2) @(negedge rxclk);
      reset_n = 1'b1;
      repeat (10) cyc();
      chk("ar_quiet", pulses, base);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side consumer of the uart block. Watches `rx_empty`, pulses `uld_rx_data` to unload each received byte, and captures `rx_data` into a DEPTH-entry byte FIFO.
- Presents buffered bytes to the system on a valid/ready stream interface.
- Runs in the uart receive clock domain (same clock as the uart `rxclk`). It frees the uart holding register quickly so that back-to-back frames do not overrun.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- AW, 4, pointer width; must equal log2(DEPTH).
- AFULL_LVL, 12, occupancy at or above which `almost_full` asserts; 1..DEPTH.

Ports:
- rxclk  in  1  clock, same as the uart receive clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_empty  in  1  from uart; 0 means a received byte is waiting.
- rx_data  in  8  from uart; valid the cycle after `uld_rx_data`.
- uld_rx_data  out  1  to uart; one-cycle unload pulse.
- flush  in  1  synchronous FIFO clear.
- out_valid  out  1  FIFO not empty.
- out_data  out  8  head-of-FIFO byte.
- out_ready  in  1  consumer accepts `out_data` when high with `out_valid`.
- count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_LVL.
- overflow_seen  out  1  sticky; set when a byte waited in the uart because the FIFO was full; cleared by `flush`.

Behaviour:
- Clock and reset: single clock `rxclk`. Reset is asynchronous and active-low on `reset_n`; all state is cleared when `reset_n`=0.
- Reset values: FSM=IDLE, `uld_rx_data`=0, pointers=0, `count`=0, `out_valid`=0, `full`=0, `almost_full`=0, `overflow_seen`=0, `out_data`=mem[0] (don't-care).
- FSM states IDLE, UNLOAD, CAPTURE:
  - IDLE: if `rx_empty`==0 and `count`<DEPTH and `flush`==0, go to UNLOAD. If `rx_empty`==0 and `count`==DEPTH, stay in IDLE and set `overflow_seen`.
  - UNLOAD: `uld_rx_data`=1 for exactly this cycle (registered output); always go to CAPTURE.
  - CAPTURE: the uart has now loaded `rx_data` and raised `rx_empty`. Write `rx_data` to mem[wr_ptr], increment `wr_ptr` mod DEPTH, go to IDLE.
  - Minimum 3 cycles per byte. IDLE never samples `rx_empty` in the cycle it could still be stale from the previous byte.
- Read side: pop when `out_valid` && `out_ready`; `rd_ptr` increments mod DEPTH. `out_data` = mem[rd_ptr], combinational from the pointer, and stable while `out_valid` && !`out_ready`.
- Occupancy:
  - Write and pop in the same cycle leaves `count` unchanged.
  - Write only: `count`+1. Pop only: `count`-1.
  - `full` and `almost_full` derive from `count` with no added latency.
  - `count` never exceeds DEPTH: the full check happens in IDLE and only one write is ever in flight.
- Pointer wrap: AW-bit pointers wrap naturally. Full/empty are determined from `count`, not pointer equality.
- `flush` (synchronous, highest priority on FIFO state):
  - Next cycle: `wr_ptr`=`rd_ptr`=0, `count`=0, `overflow_seen`=0.
  - A pop in the same cycle is ignored.
  - If `flush` is asserted in UNLOAD or CAPTURE, the FSM still completes its sequence, but the CAPTURE write is suppressed (byte discarded).
  - While `flush` is held, IDLE does not start an unload.
- Reset mid-operation: asserting `reset_n`=0 during UNLOAD forces `uld_rx_data` low immediately (async). Any partially captured byte is lost.
- No combinational path from `out_ready` to `uld_rx_data`.

Test Plan:
- Reset/idle: hold `reset_n`=0, then release with `rx_empty`=1 for 20 cycles -> `uld_rx_data` never pulses, `count`=0, `out_valid`=0.
- Single byte: drive `rx_empty`=0, and `rx_data`=8'hA5 one cycle after the `uld_rx_data` pulse with `rx_empty`=1 -> exactly one 1-cycle pulse, `count`=1 two cycles after the pulse, `out_data`=8'hA5, pop with `out_ready`=1 -> `count`=0.
- Fill and stall: 16 bytes 8'h00..8'h0F with `out_ready`=0 -> `full`=1, `almost_full` asserted at `count`=12. A 17th pending byte gets no `uld_rx_data` pulse and `overflow_seen`=1. Raise `out_ready` for one cycle -> that byte is unloaded and read order is 00..0F then the 17th.
- Simultaneous write/pop at `count`=5 -> `count` stays 5; data order preserved across the pointer wrap after 40 bytes.
- Flush during CAPTURE of 8'h3C with `count`=3 -> `count`=0, 8'h3C not stored, `overflow_seen`=0, FSM returns to IDLE.
- Async reset asserted in UNLOAD -> `uld_rx_data` drops in the same cycle, all outputs return to reset values.
